cpu_run_ctrl: RTL and testbench

//  Run/halt sequencer for the single-cycle MIPS core on the board top level.
//  - Debounces the Go push-button.
//  - Produces the CPU clock-enable at one of four Hz-selected rates.
//  - Stops the core when it executes a halting syscall; resumes it on Go.
//  - Keeps the total / taken-branch / jump instruction counters that the display mux shows.

---
 rtl/cpu_run_ctrl_pkg.sv | 16 +
 rtl/cpu_run_ctrl_if.sv | 24 ++
 rtl/cpu_run_ctrl_btn_debounce.sv | 44 ++++
 rtl/cpu_run_ctrl.sv | 118 +++++++++++
 tb/tb_cpu_run_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the run/halt sequencer:
// FSM state encoding and step-rate codes.
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } run_state_t;

  localparam logic [1:0] HZ_SLOW = 2'b00;
  localparam logic [1:0] HZ_MID  = 2'b01;
  localparam logic [1:0] HZ_FAST = 2'b10;
  localparam logic [1:0] HZ_FULL = 2'b11;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Core-side link of the run controller:
// commit enable out, per-instruction status in.
interface cpu_run_ctrl_if;

  logic cpu_ce;
  logic halt_req;
  logic branch_tkn;
  logic jump_exec;

  modport master (
    output cpu_ce,
    input  halt_req,
    input  branch_tkn,
    input  jump_exec
  );

  modport slave (
    input  cpu_ce,
    output halt_req,
    output branch_tkn,
    output jump_exec
  );

endinterface

// File: rtl/cpu_run_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop sync, stable
// counter and one-clk pulse on a debounced rise.
module cpu_run_ctrl_btn_debounce #(
  parameter int DB_CYC = 500_000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn_in,
  output logic rise
);

  localparam int CW = $clog2(DB_CYC + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          hit;

  // DB_CYC-th consecutive sample that differs
  assign hit = (sync_q[1] != level_q) &&
               (cnt_q == CW'(DB_CYC - 1));

  // sync, count differing samples, flip level
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_in};
      rise   <= hit & sync_q[1];
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (hit) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt sequencer for the MIPS core: Go
// button, rate divider, halt FSM, stat counters.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int DIV0   = 50_000_000,
  parameter int DIV1   = 5_000_000,
  parameter int DIV2   = 50_000,
  parameter int DIV3   = 1,
  parameter int DIV_W  = 26,
  parameter int DB_CYC = 500_000,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             go_in,
  input  logic [1:0]       hz,
  input  logic             cnt_clr,
  cpu_run_ctrl_if.master   core,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cnt_all,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_jmp
);

  run_state_t       state;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_last;
  logic [1:0]       hz_q;
  logic             ce_q;
  logic             go_pulse;

  cpu_run_ctrl_btn_debounce #(
    .DB_CYC (DB_CYC)
  ) u_go_db (
    .clk    (clk),
    .clr_n  (clr_n),
    .btn_in (go_in),
    .rise   (go_pulse)
  );

  assign core.cpu_ce = ce_q;

  // terminal divider count for the selected rate
  always_comb begin
    div_last = '0;
    unique case (hz)
      HZ_SLOW: div_last = DIV_W'(DIV0 - 1);
      HZ_MID:  div_last = DIV_W'(DIV1 - 1);
      HZ_FAST: div_last = DIV_W'(DIV2 - 1);
      HZ_FULL: div_last = DIV_W'(DIV3 - 1);
    endcase
  end

  // run/halt FSM with divider and commit enable
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      halted  <= 1'b0;
      div_q   <= '0;
      ce_q    <= 1'b0;
      hz_q    <= HZ_SLOW;
    end else begin
      hz_q  <= hz;
      ce_q  <= 1'b0;
      div_q <= '0;
      unique case (state)
        ST_IDLE, ST_HALT: begin
          if (go_pulse) begin
            state   <= ST_RUN;
            running <= 1'b1;
            halted  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (ce_q && core.halt_req) begin
            state   <= ST_HALT;
            running <= 1'b0;
            halted  <= 1'b1;
          end else if (hz != hz_q) begin
            div_q <= '0;
          end else if (div_q == div_last) begin
            ce_q <= 1'b1;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

  // statistics counters, clear wins over count
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_all    <= '0;
      cnt_branch <= '0;
      cnt_jmp    <= '0;
    end else if (cnt_clr) begin
      cnt_all    <= '0;
      cnt_branch <= '0;
      cnt_jmp    <= '0;
    end else begin
      cnt_all    <= cnt_all + CNT_W'(ce_q);
      cnt_branch <= cnt_branch +
                    CNT_W'(ce_q & core.branch_tkn);
      cnt_jmp    <= cnt_jmp +
                    CNT_W'(ce_q & core.jump_exec);
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: vector table
// for start-up, hand sequences for rate/halt/reset.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        clr_n;
  logic        go_in;
  logic [1:0]  hz;
  logic        cnt_clr;
  logic        running;
  logic        halted;
  logic [31:0] cnt_all;
  logic [31:0] cnt_branch;
  logic [31:0] cnt_jmp;

  int n_tests;
  int n_fail;

  cpu_run_ctrl_if bus ();

  cpu_run_ctrl #(
    .DIV0   (8),
    .DIV1   (4),
    .DIV2   (2),
    .DIV3   (1),
    .DIV_W  (26),
    .DB_CYC (4),
    .CNT_W  (32)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .go_in      (go_in),
    .hz         (hz),
    .cnt_clr    (cnt_clr),
    .core       (bus),
    .running    (running),
    .halted     (halted),
    .cnt_all    (cnt_all),
    .cnt_branch (cnt_branch),
    .cnt_jmp    (cnt_jmp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       go;
    logic       br;
    logic       jp;
    logic       clr;
    logic       ce;
    logic       run;
    int         all;
    int         nbr;
    int         njp;
  } vec_t;

  vec_t vt[15];

  function automatic vec_t mk(
    logic go, logic br, logic jp, logic clr,
    logic ce, logic run, int all, int nbr, int njp
  );
    vec_t v;
    v.go  = go;
    v.br  = br;
    v.jp  = jp;
    v.clr = clr;
    v.ce  = ce;
    v.run = run;
    v.all = all;
    v.nbr = nbr;
    v.njp = njp;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, longint act,
                     longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic wait_ce(input int lim,
                         output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.cpu_ce && n < lim);
    if (!bus.cpu_ce) n = -1;
  endtask

  int n;
  int nce;
  int a0;
  int b0;
  int j0;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clr_n   = 1'b0;
    go_in   = 1'b0;
    hz      = 2'd3;
    cnt_clr = 1'b0;
    bus.halt_req   = 1'b0;
    bus.branch_tkn = 1'b0;
    bus.jump_exec  = 1'b0;

    // start-up at hz=3: go held 10 clks
    for (int i = 0; i < 10; i++)
      vt[i] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[6]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0);
    vt[7]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 0);
    vt[8]  = mk(1, 0, 0, 0, 1, 1, 1, 0, 0);
    vt[9]  = mk(1, 1, 0, 0, 1, 1, 2, 1, 0);
    vt[10] = mk(0, 0, 1, 0, 1, 1, 3, 1, 1);
    vt[11] = mk(0, 0, 0, 0, 1, 1, 4, 1, 1);
    vt[12] = mk(0, 0, 0, 0, 1, 1, 5, 1, 1);
    vt[13] = mk(0, 0, 1, 1, 1, 1, 0, 0, 0);
    vt[14] = mk(0, 0, 0, 0, 1, 1, 1, 0, 0);

    tick();
    tick();
    chk("rst.ce", bus.cpu_ce, 0);
    chk("rst.running", running, 0);
    chk("rst.halted", halted, 0);
    chk("rst.cnt_all", cnt_all, 0);
    chk("rst.cnt_branch", cnt_branch, 0);
    chk("rst.cnt_jmp", cnt_jmp, 0);
    clr_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      go_in          = vt[i].go;
      bus.branch_tkn = vt[i].br;
      bus.jump_exec  = vt[i].jp;
      cnt_clr        = vt[i].clr;
      tick();
      chk($sformatf("row%0d.ce", i),
          bus.cpu_ce, vt[i].ce);
      chk($sformatf("row%0d.running", i),
          running, vt[i].run);
      chk($sformatf("row%0d.halted", i),
          halted, 0);
      chk($sformatf("row%0d.cnt_all", i),
          cnt_all, vt[i].all);
      chk($sformatf("row%0d.cnt_branch", i),
          cnt_branch, vt[i].nbr);
      chk($sformatf("row%0d.cnt_jmp", i),
          cnt_jmp, vt[i].njp);
    end
    bus.branch_tkn = 1'b0;
    bus.jump_exec  = 1'b0;
    cnt_clr        = 1'b0;

    // slow rate, then rate change mid-count
    hz = 2'd0;
    tick();
    chk("hz0.clear_ce", bus.cpu_ce, 0);
    chk("hz0.cnt_all", cnt_all, 2);
    wait_ce(20, n);
    chk("hz0.first_gap", n, 8);
    wait_ce(20, n);
    chk("hz0.period", n, 8);
    tick();
    tick();
    hz = 2'd1;
    tick();
    chk("hz1.clear_ce", bus.cpu_ce, 0);
    wait_ce(20, n);
    chk("hz1.gap", n, 4);

    // halting syscall together with a branch
    a0 = cnt_all;
    b0 = cnt_branch;
    j0 = cnt_jmp;
    bus.halt_req   = 1'b1;
    bus.branch_tkn = 1'b1;
    tick();
    bus.halt_req   = 1'b0;
    bus.branch_tkn = 1'b0;
    chk("halt.halted", halted, 1);
    chk("halt.running", running, 0);
    chk("halt.ce", bus.cpu_ce, 0);
    chk("halt.cnt_all", cnt_all, a0 + 1);
    chk("halt.cnt_branch", cnt_branch, b0 + 1);
    nce = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.cpu_ce) nce++;
    end
    chk("halt.ce_count", nce, 0);
    chk("halt.cnt_hold", cnt_all, a0 + 1);

    // short glitch ignored, clean press resumes
    go_in = 1'b1;
    tick();
    tick();
    go_in = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("glitch.halted", halted, 1);
    chk("glitch.running", running, 0);
    go_in = 1'b1;
    n = 0;
    while (!running && n < 20) begin
      tick();
      n++;
      if (n == 6) go_in = 1'b0;
    end
    go_in = 1'b0;
    chk("resume.running", running, 1);
    chk("resume.latency", n, 7);
    chk("resume.halted", halted, 0);
    chk("resume.cnt_all", cnt_all, a0 + 1);
    chk("resume.cnt_branch", cnt_branch, b0 + 1);
    chk("resume.cnt_jmp", cnt_jmp, j0);

    // counter wrap at 2^32
    wait_ce(20, n);
    chk("wrap.ce_seen", n > 0, 1);
    force dut.cnt_all = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_all;
    tick();
    chk("wrap.cnt_all", cnt_all, 0);

    // asynchronous reset while committing
    hz = 2'd3;
    tick();
    tick();
    chk("arst.pre_ce", bus.cpu_ce, 1);
    #3;
    clr_n = 1'b0;
    #1;
    chk("arst.ce", bus.cpu_ce, 0);
    chk("arst.running", running, 0);
    chk("arst.halted", halted, 0);
    chk("arst.cnt_all", cnt_all, 0);
    chk("arst.cnt_branch", cnt_branch, 0);
    chk("arst.cnt_jmp", cnt_jmp, 0);
    #3;
    clr_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("arst.idle_run", running, 0);
    chk("arst.idle_halt", halted, 0);
    chk("arst.idle_ce", bus.cpu_ce, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
